// File: rtl/dense_pkg.sv
// Shared defaults, derived widths and state encoding for the dense-layer sequencer.
package dense_pkg;

   localparam int IN_LEN  = 36;
   localparam int OUT_LEN = 32;
   localparam int ACC_W   = 32;
   localparam int FA_W    = $clog2(IN_LEN);
   localparam int WA_W    = $clog2(IN_LEN * OUT_LEN);
   localparam int NW      = $clog2(OUT_LEN);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s == ST_ISSUE) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/dense_beat_pipe.sv
// Delay line carrying beat tags from the read issue to the MAC stage and the capture stage.
module dense_beat_pipe #(
   parameter int NW    = 5,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   input  logic          first_i,
   input  logic          last_i,
   input  logic [NW-1:0] idx_i,
   output logic          mac_valid_o,
   output logic          mac_first_o,
   output logic          cap_valid_o,
   output logic          cap_last_o,
   output logic [NW-1:0] cap_idx_o,
   output logic          busy_o
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] first_q;
   logic [DEPTH-1:0] last_q;
   logic [NW-1:0]    idx_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         first_q <= '0;
         last_q  <= '0;
         for (int k = 0; k < DEPTH; k++) idx_q[k] <= '0;
      end else begin
         valid_q[0] <= valid_i;
         first_q[0] <= first_i;
         last_q[0]  <= last_i;
         idx_q[0]   <= idx_i;
         for (int k = 1; k < DEPTH; k++) begin
            valid_q[k] <= valid_q[k-1];
            first_q[k] <= first_q[k-1];
            last_q[k]  <= last_q[k-1];
            idx_q[k]   <= idx_q[k-1];
         end
      end
   end

   // Stage 0 lines up with returning memory data, the final stage with the MAC result.
   assign mac_valid_o = valid_q[0];
   assign mac_first_o = first_q[0];
   assign cap_valid_o = valid_q[DEPTH-1];
   assign cap_last_o  = last_q[DEPTH-1];
   assign cap_idx_o   = idx_q[DEPTH-1];
   assign busy_o      = |valid_q;

endmodule

// File: rtl/dense_seq_ctrl.sv
// Dense-layer sequencer: walks neurons x inputs, drives memory reads and MAC strobes, captures results.
module dense_seq_ctrl
   import dense_pkg::*;
#(
   parameter int IN_LEN  = dense_pkg::IN_LEN,
   parameter int OUT_LEN = dense_pkg::OUT_LEN,
   parameter int ACC_W   = dense_pkg::ACC_W,
   parameter int FA_W    = $clog2(IN_LEN),
   parameter int WA_W    = $clog2(IN_LEN * OUT_LEN),
   parameter int NW      = $clog2(OUT_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [FA_W-1:0]  feat_addr,
   output logic [WA_W-1:0]  w_addr,
   output logic             rd_en,
   output logic             mac_en,
   output logic             mac_clr,
   input  logic [ACC_W-1:0] mac_acc,
   output logic [ACC_W-1:0] out_data,
   output logic [NW-1:0]    out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_ovf
);

   localparam logic [FA_W-1:0] I_LAST = FA_W'(IN_LEN - 1);
   localparam logic [NW-1:0]   O_LAST = NW'(OUT_LEN - 1);

   state_e           state_q, state_d;
   logic [FA_W-1:0]  i_q, i_d;
   logic [NW-1:0]    o_q, o_d;
   logic [WA_W-1:0]  w_addr_q, w_addr_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic [NW-1:0]    out_idx_q, out_idx_d;
   logic             out_valid_q, out_valid_d;
   logic             err_ovf_q, err_ovf_d;

   logic             stall, beat, beat_first, beat_last, final_beat, capture;
   logic             mac_valid, mac_first, cap_valid, cap_last, pipe_busy;
   logic [NW-1:0]    cap_idx;

   // A held, unaccepted result freezes issue so no capture can land on it.
   assign stall      = out_valid_q & ~out_ready;
   assign beat       = (state_q == ST_ISSUE) & ~stall;
   assign beat_first = (i_q == '0);
   assign beat_last  = (i_q == I_LAST);
   assign final_beat = beat & beat_last & (o_q == O_LAST);
   assign capture    = cap_valid & cap_last;

   dense_beat_pipe #(
      .NW    (NW),
      .DEPTH (2)
   ) u_pipe (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (beat),
      .first_i     (beat_first),
      .last_i      (beat_last),
      .idx_i       (o_q),
      .mac_valid_o (mac_valid),
      .mac_first_o (mac_first),
      .cap_valid_o (cap_valid),
      .cap_last_o  (cap_last),
      .cap_idx_o   (cap_idx),
      .busy_o      (pipe_busy)
   );

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      o_d      = o_q;
      w_addr_d = w_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_ISSUE;
               i_d      = '0;
               o_d      = '0;
               w_addr_d = '0;
            end
         end
         ST_ISSUE: begin
            if (beat) begin
               w_addr_d = w_addr_q + WA_W'(1);
               if (beat_last) begin
                  i_d = '0;
                  o_d = (o_q == O_LAST) ? '0 : o_q + NW'(1);
               end else begin
                  i_d = i_q + FA_W'(1);
               end
               if (final_beat) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!pipe_busy && (!out_valid_q || out_ready)) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      err_ovf_d   = err_ovf_q;
      if (capture) begin
         out_data_d  = mac_acc;
         out_idx_d   = cap_idx;
         out_valid_d = 1'b1;
         if (out_valid_q && !out_ready) err_ovf_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         o_q         <= '0;
         w_addr_q    <= '0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         o_q         <= o_d;
         w_addr_q    <= w_addr_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign busy      = is_busy(state_q);
   assign done      = (state_q == ST_DONE);
   assign feat_addr = i_q;
   assign w_addr    = w_addr_q;
   assign rd_en     = beat;
   assign mac_en    = mac_valid;
   assign mac_clr   = mac_valid & mac_first;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Directed bench for dense_seq_ctrl with behavioural feature/weight memories and MAC.
module tb_dense_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done, rd_en, mac_en, mac_clr, out_valid, out_ready, err_ovf;
   logic [5:0]  feat_addr;
   logic [10:0] w_addr;
   logic [31:0] mac_acc, out_data;
   logic [4:0]  out_idx;

   dense_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .feat_addr (feat_addr),
      .w_addr    (w_addr),
      .rd_en     (rd_en),
      .mac_en    (mac_en),
      .mac_clr   (mac_clr),
      .mac_acc   (mac_acc),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_ovf   (err_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memories with one-cycle registered read, feeding a registered accumulator.
   logic [31:0] feat_d, w_d, acc;

   function automatic logic [31:0] feat_val(input logic [5:0] a);
      return (mode == 1) ? 32'(a) + 32'd1 : 32'd1;
   endfunction

   function automatic logic [31:0] wt_val(input logic [10:0] a);
      return (mode == 1) ? 32'(a / 11'd36) : 32'd1;
   endfunction

   always @(posedge clk) begin
      if (rd_en) begin
         feat_d <= feat_val(feat_addr);
         w_d    <= wt_val(w_addr);
      end
      if (mac_en) acc <= mac_clr ? feat_d * w_d : acc + feat_d * w_d;
   end
   assign mac_acc = acc;

   // Passive monitor: records handshakes, done pulses and the read address stream.
   logic [31:0] res_data [512];
   logic [4:0]  res_idx  [512];
   int hs_total = 0, done_total = 0, done_cyc = 0, rd_total = 0;
   int gap_cnt = 0, abad_cnt = 0, last_w = 0;

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (hs_total < 512) begin
            res_data[hs_total] = out_data;
            res_idx[hs_total]  = out_idx;
         end
         hs_total++;
      end
      if (done) begin
         done_total++;
         done_cyc = cyc;
      end
      if (rd_en) begin
         if (int'(w_addr) != 0 && int'(w_addr) != last_w + 1) gap_cnt++;
         if (int'(feat_addr) != int'(w_addr) % 36) abad_cnt++;
         last_w = int'(w_addr);
         rd_total++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({busy, done, feat_addr, w_addr, rd_en, mac_en, mac_clr,
                  out_data, out_idx, out_valid, err_ovf});
   endfunction

   int start_cyc;

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_wait(input string tag, input int done_base, input bit rand_ready);
      bit seen = 0;
      for (int n = 0; n < 6000; n++) begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         if (done_total > done_base) begin
            seen = 1;
            break;
         end
      end
      out_ready = 1'b1;
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      chk({tag, "_done_once"}, 64'(done_total - done_base), 64'd1);
   endtask

   task automatic check_run(input string tag, input int m, input int hs_base);
      int bad = 0;
      logic [31:0] exp_v;
      chk({tag, "_hs_count"}, 64'(hs_total - hs_base), 64'd32);
      for (int k = 0; k < 32; k++) begin
         exp_v = (m == 1) ? 32'(k * 666) : 32'd36;
         if (res_data[hs_base + k] !== exp_v || res_idx[hs_base + k] !== 5'(k)) bad++;
      end
      chk({tag, "_bad_results"}, 64'(bad), 64'd0);
      chk({tag, "_last_data"}, 64'(res_data[hs_base + 31]), (m == 1) ? 64'(31 * 666) : 64'd36);
      chk({tag, "_err_ovf"}, 64'(err_ovf), 64'd0);
   endtask

   initial begin
      int hs_b, dn_b, rd_b, gap_b, abad_b, lat, bad, rd_stall;
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("reset_outputs_zero", all_outs(), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("idle_after_reset", all_outs(), 64'd0);

      // Run 1: unit data and weights, consumer always ready.
      mode = 0;
      hs_b = hs_total; dn_b = done_total;
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'd1);
      run_wait("run1", dn_b, 0);
      lat = done_cyc - start_cyc;
      chk("run1_latency_in_range", 64'(lat >= 1154 && lat <= 1156), 64'd1);
      check_run("run1", 0, hs_b);
      $display("run1: results=%0d latency=%0d", hs_total - hs_b, lat);

      // Run 2: data=i+1, weight=o; also audit the address stream.
      mode = 1;
      hs_b = hs_total; dn_b = done_total; rd_b = rd_total; gap_b = gap_cnt; abad_b = abad_cnt;
      pulse_start();
      run_wait("run2", dn_b, 0);
      check_run("run2", 1, hs_b);
      chk("run2_read_beats", 64'(rd_total - rd_b), 64'd1152);
      chk("run2_waddr_gaps", 64'(gap_cnt - gap_b), 64'd0);
      chk("run2_feat_addr_align", 64'(abad_cnt - abad_b), 64'd0);
      chk("run2_last_waddr", 64'(last_w), 64'd1151);
      $display("run2: results=%0d beats=%0d", hs_total - hs_b, rd_total - rd_b);

      // Run 3: consumer stalls for 50 cycles once the first result is held.
      mode = 0;
      out_ready = 1'b0;
      hs_b = hs_total; dn_b = done_total;
      pulse_start();
      bad = 1;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            bad = 0;
            break;
         end
      end
      chk("run3_first_result_seen", 64'(bad), 64'd0);
      rd_stall = 0; bad = 0;
      for (int n = 0; n < 50; n++) begin
         if (n > 0 && rd_en) rd_stall++;
         if (out_data !== 32'd36 || !out_valid) bad++;
         @(posedge clk); #1;
      end
      chk("run3_rd_en_during_stall", 64'(rd_stall), 64'd0);
      chk("run3_data_held", 64'(bad), 64'd0);
      chk("run3_no_hs_during_stall", 64'(hs_total - hs_b), 64'd0);
      chk("run3_err_ovf_stall", 64'(err_ovf), 64'd0);
      out_ready = 1'b1;
      run_wait("run3", dn_b, 0);
      check_run("run3", 0, hs_b);
      $display("run3: results=%0d after 50-cycle stall", hs_total - hs_b);

      // Run 4: a second start pulse mid-run must be ignored.
      mode = 1;
      hs_b = hs_total; dn_b = done_total;
      pulse_start();
      repeat (98) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_wait("run4", dn_b, 0);
      lat = done_cyc - start_cyc;
      chk("run4_latency_unchanged", 64'(lat >= 1154 && lat <= 1156), 64'd1);
      check_run("run4", 1, hs_b);
      $display("run4: results=%0d latency=%0d", hs_total - hs_b, lat);

      // Run 5: reset at beat 500, then a full clean run.
      mode = 0;
      dn_b = done_total; rd_b = rd_total;
      pulse_start();
      for (int n = 0; n < 2000; n++) begin
         @(posedge clk); #1;
         if (rd_total - rd_b >= 500) break;
      end
      rst = 1'b1;
      #1;
      bad = (all_outs() !== 64'd0) ? 1 : 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (all_outs() !== 64'd0) bad++;
      end
      chk("run5_outputs_zero_in_reset", 64'(bad), 64'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("run5_no_stale_valid", 64'({out_valid, busy}), 64'd0);
      chk("run5_no_done_after_abort", 64'(done_total - dn_b), 64'd0);
      mode = 1;
      hs_b = hs_total; dn_b = done_total;
      pulse_start();
      run_wait("run5", dn_b, 0);
      check_run("run5", 1, hs_b);
      $display("run5: results=%0d after mid-run reset", hs_total - hs_b);

      // Run 6: consumer readiness toggles randomly every cycle.
      mode = 0;
      hs_b = hs_total; dn_b = done_total;
      pulse_start();
      run_wait("run6", dn_b, 1);
      check_run("run6", 0, hs_b);
      $display("run6: results=%0d with random ready", hs_total - hs_b);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
